softmax_argmax: RTL and testbench
=================================

Name: softmax_argmax

Overview:
- Consumes the float32 probability stream from the softmax stage and reduces each frame of C values to a top-1 decision: the winning class index and its probability.
- Flags low-confidence results and any NaN seen in the frame.
- Sits directly downstream of softmax; its result feeds the classification result register/host readout.

Parameters:
- C, 1536, number of class probabilities per frame.
- DATA_WIDTH, 32, element width; IEEE-754 single precision, fixed at 32.
- THRESH, 32'h3F000000 (0.5), float32 bit pattern. The result is low-confidence when the winning value is strictly below this.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  pxl_in carries one probability this cycle.
- pxl_in  in  32  float32 probability, class order 0..C-1.
- class_out  out  $clog2(C)  index of the winning class.
- prob_out  out  32  float32 value of the winning class.
- low_conf  out  1  prob_out < THRESH.
- nan_seen  out  1  at least one NaN was received in the frame.
- valid_out  out  1  one-cycle strobe; all result outputs are valid.
- busy  out  1  a frame is partially received.

Behaviour:
- Reset (asynchronous, reset=1):
  - All outputs are 0.
  - Element counter, best index, best value and NaN sticky are all 0.
  - FSM goes to IDLE.
  - Reset mid-frame discards the partial frame; no valid_out follows.
- FSM has two states, IDLE and ACCUM. busy=1 exactly in ACCUM.
  - IDLE + valid_in: the element is index 0. Load best_val=pxl_in and best_idx=0, clear the NaN sticky, set cnt=1, go to ACCUM.
    - If this element is NaN: set the sticky and load best_val=32'h00000000 with best_idx=0.
  - ACCUM + valid_in: the element is index cnt. Update best if pxl_in > best_val (strict), then cnt++.
  - When the accepted element has index C-1: return to IDLE and register the results, so valid_out=1 on the next cycle.
  - If C==1, the first element completes the frame.
  - valid_in low: hold all state. Arbitrary gaps are allowed; there is no timeout.
- Latency: valid_out asserts exactly 1 cycle after the cycle in which element C-1 is accepted. It is high for 1 cycle.
- Result outputs hold their values until the next valid_out or reset.
- Back-to-back frames: element 0 of the next frame may arrive in the same cycle valid_out is high. It is accepted with no bubble.
- Float comparison (combinational):
  - Magnitudes compare on bits [30:0]; the sign is bit 31.
  - +0 and -0 are equal.
  - For two negatives, the larger magnitude is the smaller value.
  - NaN is exponent 0xFF with nonzero mantissa. A NaN input never wins; it sets nan_seen for the frame.
  - +Inf is a legal winner. Denormals compare by bits, with no flush.
- Ties: the strict greater-than rule keeps the lowest index.
- low_conf = (prob_out < THRESH) using the same comparator. It is registered together with valid_out.
- No backpressure: this block is always ready, matching the upstream protocol, which has no ready signal.

Decomposition:
- Shared package:
  - FP32 field constants: sign bit 31, exponent [30:23], mantissa [22:0], EXP_MAX=8'hFF.
  - FP_POS_ZERO.
  - An is_nan function.
  - FSM state encoding (IDLE, ACCUM).
- One combinational sub-module, fp32_gt: inputs a, b; output a_gt_b, with NaN on either input giving 0.
  - Instantiated twice: once for the running max and once for the THRESH check.

Test Plan (C=4 unless noted):
- Stimulus: 0x3DCCCCCD(0.1), 0x3E4CCCCD(0.2), 0x3F000000(0.5), 0x3E4CCCCD(0.2), contiguous.
  - Required: valid_out exactly 1 cycle after the 4th element; class_out=2, prob_out=0x3F000000, low_conf=0 (0.5 is not < 0.5), nan_seen=0.
- Stimulus: 0x3E800000 ×4 (ties, 0.25) with 2-cycle gaps between elements.
  - Required: class_out=0, prob_out=0x3E800000, low_conf=1; busy=1 from the 1st element until the 4th is accepted.
- Stimulus: 0x7FC00000(NaN), 0x3E800000, 0x3F400000(0.75), 0x00000000.
  - Required: class_out=2, prob_out=0x3F400000, nan_seen=1, low_conf=0.
- Stimulus: two frames back-to-back with no idle cycle, [0.1, 0.2, 0.5, 0.2] then [0.5, 0.1, 0.1, 0.3].
  - Required: valid_out pulses twice; results are 2/0x3F000000, then 0/0x3F000000; the second frame's element 0 is accepted in the same cycle as the first valid_out.
- Stimulus: send 2 elements, assert reset for 1 cycle, then send frame [0.1, 0.1, 0.1, 0.7 (0x3F333333)].
  - Required: all outputs are 0 during reset, with no valid_out for the aborted frame; then class_out=3, prob_out=0x3F333333.
- Stimulus: negatives and signed zero: 0x80000000(-0), 0xBF800000(-1), 0x00000000(+0), 0xC0000000(-2).
  - Required: class_out=0 (+0 equals -0), prob_out=0x80000000.

Source files
------------

// File: rtl/softmax_argmax_pkg.sv
// softmax_argmax_pkg: float32 field layout, NaN test and FSM encoding shared by the top-1 reducer.
package softmax_argmax_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_MSB = 22;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  typedef enum logic {IDLE, ACCUM} state_t;
  function automatic logic is_nan(input logic [31:0] x);
    return x[EXP_MSB:EXP_LSB] == EXP_MAX && x[MAN_MSB:0] != '0;
  endfunction
endpackage

// File: rtl/softmax_argmax_fp32_gt.sv
// fp32_gt: strict float32 a > b on raw bits; signed zeros are equal and any NaN operand yields 0.
module fp32_gt
  import softmax_argmax_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b
);
  logic both_zero;
  always_comb begin
    both_zero = a[EXP_MSB:0] == '0 && b[EXP_MSB:0] == '0;
    a_gt_b = (is_nan(a) || is_nan(b) || both_zero) ? 1'b0 :
             (a[SIGN_BIT] != b[SIGN_BIT]) ? !a[SIGN_BIT] :
             a[SIGN_BIT] ? (a[EXP_MSB:0] < b[EXP_MSB:0]) : (a[EXP_MSB:0] > b[EXP_MSB:0]);
  end
endmodule

// File: rtl/softmax_argmax.sv
// softmax_argmax: reduces each frame of C float32 probabilities to the winning index, value and flags.
module softmax_argmax
  import softmax_argmax_pkg::*;
#(
  parameter int C = 1536,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] THRESH = 32'h3F00_0000,
  localparam int IW = (C > 1) ? $clog2(C) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [IW-1:0]         class_out,
  output logic [DATA_WIDTH-1:0] prob_out,
  output logic                  low_conf,
  output logic                  nan_seen,
  output logic                  valid_out,
  output logic                  busy
);
  state_t state;
  logic [IW-1:0] cnt, best_idx, idx, n_idx;
  logic [DATA_WIDTH-1:0] best_val, n_val;
  logic nan_sticky, n_nan, first, in_nan, gt, lt, last;
  fp32_gt u_max (.a(pxl_in), .b(best_val), .a_gt_b(gt));
  // Threshold is checked against the value about to be registered, so low_conf lands with valid_out.
  fp32_gt u_thr (.a(THRESH), .b(n_val), .a_gt_b(lt));
  always_comb begin
    first = state == IDLE;
    in_nan = is_nan(pxl_in);
    idx = first ? '0 : cnt;
    n_val = first ? (in_nan ? FP_POS_ZERO : pxl_in) : (gt ? pxl_in : best_val);
    n_idx = first ? '0 : (gt ? cnt : best_idx);
    n_nan = in_nan | (!first & nan_sticky);
    last = idx == IW'(C - 1);
  end
  assign busy = state == ACCUM;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      best_idx <= '0;
      best_val <= '0;
      nan_sticky <= 1'b0;
      class_out <= '0;
      prob_out <= '0;
      low_conf <= 1'b0;
      nan_seen <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        best_val <= n_val;
        best_idx <= n_idx;
        nan_sticky <= n_nan;
        cnt <= last ? '0 : idx + 1'b1;
        state <= last ? IDLE : ACCUM;
        if (last) begin
          class_out <= n_idx;
          prob_out <= n_val;
          low_conf <= lt;
          nan_seen <= n_nan;
          valid_out <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_softmax_argmax.sv
// tb_softmax_argmax: table-driven frames with a result scoreboard, plus reset/abort and busy sequences.
module tb_softmax_argmax;
  logic clk = 1'b0, reset = 1'b1, valid_in = 1'b0;
  logic [31:0] pxl_in = '0;
  logic [1:0] class_out;
  logic [31:0] prob_out;
  logic low_conf, nan_seen, valid_out, busy;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic [31:0] d [4];
    int gap;
    bit b2b;
    logic [1:0] cls;
    logic [31:0] prob;
    logic low, nan;
  } vec_t;
  typedef struct {
    logic [1:0] cls;
    logic [31:0] prob;
    logic low, nan;
    int cyc;
  } exp_t;
  exp_t sb [$];
  vec_t vecs [9];

  softmax_argmax #(.C(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .class_out(class_out), .prob_out(prob_out), .low_conf(low_conf),
    .nan_seen(nan_seen), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid_out) begin
      if (sb.size() == 0) check("unexpected_valid_out", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", cyc, e.cyc);
        check("class_out", {30'd0, class_out}, {30'd0, e.cls});
        check("prob_out", prob_out, e.prob);
        check("low_conf", {31'd0, low_conf}, {31'd0, e.low});
        check("nan_seen", {31'd0, nan_seen}, {31'd0, e.nan});
      end
    end
  end

  task automatic drive(input logic [31:0] v);
    @(posedge clk); #1;
    valid_in = 1'b1;
    pxl_in = v;
  endtask

  task automatic idle(input int n, input bit chk, input logic exp_busy);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      @(negedge clk);
      if (chk) check("busy", {31'd0, busy}, {31'd0, exp_busy});
    end
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    for (int j = 0; j < 4; j++) begin
      drive(v.d[j]);
      if (j == 3) begin
        e.cls = v.cls; e.prob = v.prob; e.low = v.low; e.nan = v.nan; e.cyc = cyc + 1;
        sb.push_back(e);
      end
      if (v.gap > 0) idle(v.gap, 1'b1, j < 3);
    end
    if (!v.b2b && v.gap == 0) idle(1, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_class"}, {30'd0, class_out}, 32'd0);
    check({tag, "_prob"}, prob_out, 32'd0);
    check({tag, "_flags"}, {28'd0, low_conf, nan_seen, valid_out, busy}, 32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{d: '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3F000000, 32'h3E4CCCCD}, gap: 0, b2b: 0, cls: 2, prob: 32'h3F000000, low: 0, nan: 0};
    vecs[1] = '{d: '{32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3E800000}, gap: 2, b2b: 0, cls: 0, prob: 32'h3E800000, low: 1, nan: 0};
    vecs[2] = '{d: '{32'h7FC00000, 32'h3E800000, 32'h3F400000, 32'h00000000}, gap: 0, b2b: 0, cls: 2, prob: 32'h3F400000, low: 0, nan: 1};
    vecs[3] = '{d: '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3F000000, 32'h3E4CCCCD}, gap: 0, b2b: 1, cls: 2, prob: 32'h3F000000, low: 0, nan: 0};
    vecs[4] = '{d: '{32'h3F000000, 32'h3DCCCCCD, 32'h3DCCCCCD, 32'h3E99999A}, gap: 0, b2b: 0, cls: 0, prob: 32'h3F000000, low: 0, nan: 0};
    vecs[5] = '{d: '{32'h80000000, 32'hBF800000, 32'h00000000, 32'hC0000000}, gap: 0, b2b: 0, cls: 0, prob: 32'h80000000, low: 1, nan: 0};
    vecs[6] = '{d: '{32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h7F7FFFFF}, gap: 0, b2b: 0, cls: 1, prob: 32'h7F800000, low: 0, nan: 0};
    vecs[7] = '{d: '{32'h00000001, 32'h00000003, 32'h00000002, 32'h80000005}, gap: 0, b2b: 0, cls: 1, prob: 32'h00000003, low: 1, nan: 0};
    vecs[8] = '{d: '{32'hBF800000, 32'hC0000000, 32'hBF000000, 32'h7FC00001}, gap: 1, b2b: 0, cls: 2, prob: 32'hBF000000, low: 1, nan: 1};

    #2;
    check_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    for (int i = 0; i < 9; i++) send_frame(vecs[i]);

    drive(32'h3F7FFFFF);
    drive(32'h3F7FFFFF);
    @(posedge clk); #1;
    valid_in = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_frame_reset");
    @(posedge clk); #1 reset = 1'b0;
    v = '{d: '{32'h3DCCCCCD, 32'h3DCCCCCD, 32'h3DCCCCCD, 32'h3F333333}, gap: 0, b2b: 0, cls: 3, prob: 32'h3F333333, low: 0, nan: 0};
    send_frame(v);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    idle(2, 1'b1, 1'b0);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("prob_held", prob_out, 32'h3F333333);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
